// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // i_data_bits encoding: data bits per frame = 5 + value
  localparam logic [1:0] DBITS_5 = 2'd0;
  localparam logic [1:0] DBITS_6 = 2'd1;
  localparam logic [1:0] DBITS_7 = 2'd2;
  localparam logic [1:0] DBITS_8 = 2'd3;

  // Parity sense as carried by i_parity_odd
  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_e;

  // Decode the data-bits field and clamp it to what the datapath can hold.
  function automatic logic [3:0] data_bits_count(input logic [1:0] sel,
                                                 input int max_bits);
    int n;
    n = 5;
    case (sel)
      DBITS_5: n = 5;
      DBITS_6: n = 6;
      DBITS_7: n = 7;
      DBITS_8: n = 8;
      default: n = 5;
    endcase
    if (n > max_bits) n = max_bits;
    return n[3:0];
  endfunction

endpackage

// File: rtl/uart_rx_majority_sampler.sv
// rx_majority_sampler: line synchronizer, oversample tick counter and
// 3-sample majority vote around the bit centre.
module rx_majority_sampler
  import uart_pkg::*;
#(
  parameter int OVER_SAMPLE = 16,
  parameter int MID_SAMPLE  = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_stick,
  input  logic i_rx_serial,
  input  logic i_cnt_clr,
  output logic o_rx_line,
  output logic o_rx_fall,
  output logic o_vote,
  output logic o_vote_valid,
  output logic o_bit_end
);

  localparam int CNT_W = (OVER_SAMPLE > 2) ? $clog2(OVER_SAMPLE) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVER_SAMPLE - 1);
  localparam logic [CNT_W-1:0] TICK_S0   = CNT_W'(MID_SAMPLE - 1);
  localparam logic [CNT_W-1:0] TICK_S1   = CNT_W'(MID_SAMPLE);
  localparam logic [CNT_W-1:0] TICK_S2   = CNT_W'(MID_SAMPLE + 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             line_prev;
  logic [CNT_W-1:0] tick_cnt;
  logic             samp_a;
  logic             samp_b;
  logic             tick_ok;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection; idle-high reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q1   <= 1'b1;
      sync_q2   <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync_q1   <= i_rx_serial;
      sync_q2   <= sync_q1;
      line_prev <= sync_q2;
    end
  end

  assign tick_ok = i_stick & ~i_cnt_clr;

  // Tick index within the current bit; held at zero while the FSM is idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_cnt <= '0;
    end else if (i_cnt_clr) begin
      tick_cnt <= '0;
    end else if (i_stick) begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

  // Capture the first two of the three centre samples
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      samp_a <= 1'b0;
      samp_b <= 1'b0;
    end else if (tick_ok) begin
      if (tick_cnt == TICK_S0) samp_a <= sync_q2;
      if (tick_cnt == TICK_S1) samp_b <= sync_q2;
    end
  end

  // Third sample is taken live, so the vote is ready on the MID_SAMPLE+1 tick itself
  assign o_vote       = (samp_a & samp_b) | (samp_a & sync_q2) | (samp_b & sync_q2);
  assign o_vote_valid = tick_ok & (tick_cnt == TICK_S2);
  assign o_bit_end    = tick_ok & (tick_cnt == TICK_LAST);
  assign o_rx_line    = sync_q2;
  assign o_rx_fall    = line_prev & ~sync_q2;

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver (5..8 data bits, 1/2 stop,
// optional parity). Define UART_RX_PARITY_EN to build the parity checker.
//
//  state        | meaning
//  -------------+-----------------------------------------------------------
//  ST_IDLE      | line idle, waiting for a synchronised falling edge
//  ST_START     | validating start bit; vote of 1 is a false start
//  ST_DATA      | shifting data bits in LSB-first
//  ST_PARITY    | checking the parity bit (parity build only)
//  ST_STOP      | sampling 1 or 2 stop bits; delivers at the final stop vote
//  ST_WAIT_IDLE | stop bit was low (framing error / break); wait for line high
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int SIZE_DATA   = 8,
  parameter int OVER_SAMPLE = 16,
  parameter int MID_SAMPLE  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_stick,
  input  logic                 i_rx_en,
  input  logic                 i_fifo_full,
  input  logic                 i_rx_serial,
  input  logic [1:0]           i_data_bits,
  input  logic                 i_two_stop,
  input  logic                 i_parity_en,
  input  logic                 i_parity_odd,
  output logic [SIZE_DATA-1:0] o_rx_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun_err,
  output logic                 o_busy
);

  rx_state_e state_q, state_nxt;

  logic                 rx_line;
  logic                 rx_fall;
  logic                 vote;
  logic                 vote_valid;
  logic                 bit_end;

  logic [2:0]           bit_cnt_q, bit_cnt_nxt;
  logic                 stop_cnt_q, stop_cnt_nxt;
  logic [SIZE_DATA-1:0] shift_q, shift_nxt;
  logic [3:0]           nbits_q, nbits_nxt;
  logic                 two_stop_q, two_stop_nxt;
  logic                 par_bad_q, par_bad_nxt;
  logic [SIZE_DATA-1:0] rx_data_nxt;
  logic                 done_nxt, ferr_nxt, perr_nxt, oerr_nxt;
  logic                 deliver;
  logic                 stop_bad;

`ifdef UART_RX_PARITY_EN
  logic                 par_en_q, par_en_nxt;
  parity_mode_e         par_mode_q, par_mode_nxt;
`else
  logic                 unused_parity;
  assign unused_parity = i_parity_en ^ i_parity_odd;
`endif

  rx_majority_sampler #(
    .OVER_SAMPLE (OVER_SAMPLE),
    .MID_SAMPLE  (MID_SAMPLE)
  ) u_sampler (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_stick      (i_stick),
    .i_rx_serial  (i_rx_serial),
    .i_cnt_clr    (state_q == ST_IDLE),
    .o_rx_line    (rx_line),
    .o_rx_fall    (rx_fall),
    .o_vote       (vote),
    .o_vote_valid (vote_valid),
    .o_bit_end    (bit_end)
  );

  // State, frame configuration, shift register and registered output pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      stop_cnt_q    <= 1'b0;
      shift_q       <= '0;
      nbits_q       <= 4'd0;
      two_stop_q    <= 1'b0;
      par_bad_q     <= 1'b0;
      o_rx_data     <= '0;
      o_rx_done     <= 1'b0;
      o_frame_err   <= 1'b0;
      o_parity_err  <= 1'b0;
      o_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q      <= 1'b0;
      par_mode_q    <= PAR_EVEN;
`endif
    end else begin
      state_q       <= state_nxt;
      bit_cnt_q     <= bit_cnt_nxt;
      stop_cnt_q    <= stop_cnt_nxt;
      shift_q       <= shift_nxt;
      nbits_q       <= nbits_nxt;
      two_stop_q    <= two_stop_nxt;
      par_bad_q     <= par_bad_nxt;
      o_rx_data     <= rx_data_nxt;
      o_rx_done     <= done_nxt;
      o_frame_err   <= ferr_nxt;
      o_parity_err  <= perr_nxt;
      o_overrun_err <= oerr_nxt;
`ifdef UART_RX_PARITY_EN
      par_en_q      <= par_en_nxt;
      par_mode_q    <= par_mode_nxt;
`endif
    end
  end

  // Next-state, datapath updates and delivery decision
  always_comb begin
    state_nxt    = state_q;
    bit_cnt_nxt  = bit_cnt_q;
    stop_cnt_nxt = stop_cnt_q;
    shift_nxt    = shift_q;
    nbits_nxt    = nbits_q;
    two_stop_nxt = two_stop_q;
    par_bad_nxt  = par_bad_q;
    rx_data_nxt  = o_rx_data;
    done_nxt     = 1'b0;
    ferr_nxt     = 1'b0;
    perr_nxt     = 1'b0;
    oerr_nxt     = 1'b0;
    deliver      = 1'b0;
    stop_bad     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en_nxt   = par_en_q;
    par_mode_nxt = par_mode_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_rx_en && rx_fall) begin
          state_nxt    = ST_START;
          nbits_nxt    = data_bits_count(i_data_bits, SIZE_DATA);
          two_stop_nxt = i_two_stop;
          bit_cnt_nxt  = '0;
          stop_cnt_nxt = 1'b0;
          shift_nxt    = '0;
          par_bad_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
          par_en_nxt   = i_parity_en;
          par_mode_nxt = i_parity_odd ? PAR_ODD : PAR_EVEN;
`endif
        end
      end

      ST_START: begin
        if (vote_valid && vote) begin
          state_nxt = ST_IDLE;
        end else if (bit_end) begin
          state_nxt = ST_DATA;
        end
      end

      ST_DATA: begin
        if (vote_valid) begin
          for (int i = 0; i < SIZE_DATA; i++) begin
            if (bit_cnt_q == 3'(i)) shift_nxt[i] = vote;
          end
        end
        if (bit_end) begin
          if ({1'b0, bit_cnt_q} == nbits_q - 4'd1) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = par_en_q ? ST_PARITY : ST_STOP;
`else
            state_nxt = ST_STOP;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt_q + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        // Even-parity bit is the XOR of the data; odd sense inverts it
        if (vote_valid) begin
          par_bad_nxt = vote != ((^shift_q) ^ (par_mode_q == PAR_ODD));
        end
        if (bit_end) state_nxt = ST_STOP;
      end
`endif

      ST_STOP: begin
        if (vote_valid) begin
          if (!vote) begin
            deliver   = 1'b1;
            stop_bad  = 1'b1;
            state_nxt = ST_WAIT_IDLE;
          end else if (stop_cnt_q == two_stop_q) begin
            // Leave before the bit ends so a back-to-back start edge is not missed
            deliver   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end else if (bit_end) begin
          stop_cnt_nxt = 1'b1;
        end
      end

      ST_WAIT_IDLE: begin
        if (rx_line) state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase

    if (deliver) begin
      ferr_nxt = stop_bad;
`ifdef UART_RX_PARITY_EN
      perr_nxt = par_bad_q;
`endif
      if (i_fifo_full) begin
        oerr_nxt = 1'b1;
      end else begin
        done_nxt    = 1'b1;
        rx_data_nxt = shift_q;
      end
    end

    // Disabling the receiver abandons the frame silently
    if (!i_rx_en) begin
      state_nxt   = ST_IDLE;
      rx_data_nxt = o_rx_data;
      done_nxt    = 1'b0;
      ferr_nxt    = 1'b0;
      perr_nxt    = 1'b0;
      oerr_nxt    = 1'b0;
    end
  end

  assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: stimulus pushes expected deliveries,
// a monitor pops and compares whenever the DUT pulses an output.
module tb_uart_rx_cfg;

  localparam int SIZE_DATA = 8;
  localparam int OS        = 16;
  localparam int MID       = 8;
  localparam int TICK_DIV  = 4;
  localparam int BIT_CLK   = OS * TICK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stick = 1'b0;
  logic       rx_en = 1'b1;
  logic       fifo_full = 1'b0;
  logic       rx_serial = 1'b1;
  logic [1:0] data_bits = 2'd3;
  logic       two_stop = 1'b0;
  logic       par_en = 1'b0;
  logic       par_odd = 1'b0;

  logic [SIZE_DATA-1:0] rx_data;
  logic rx_done, frame_err, parity_err, overrun_err, busy;

  typedef struct {
    logic       done;
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    logic       oerr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  uart_rx_cfg #(
    .SIZE_DATA   (SIZE_DATA),
    .OVER_SAMPLE (OS),
    .MID_SAMPLE  (MID)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_stick       (stick),
    .i_rx_en       (rx_en),
    .i_fifo_full   (fifo_full),
    .i_rx_serial   (rx_serial),
    .i_data_bits   (data_bits),
    .i_two_stop    (two_stop),
    .i_parity_en   (par_en),
    .i_parity_odd  (par_odd),
    .o_rx_data     (rx_data),
    .o_rx_done     (rx_done),
    .o_frame_err   (frame_err),
    .o_parity_err  (parity_err),
    .o_overrun_err (overrun_err),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      stick = 1'b1;
      @(negedge clk);
      stick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any output pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && (rx_done || frame_err || parity_err || overrun_err)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_delivery: done=%0b ferr=%0b perr=%0b oerr=%0b data=0x%0h, expected none at %0t",
                 rx_done, frame_err, parity_err, overrun_err, rx_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_done",     32'(rx_done),     32'(mon_e.done));
        check("rx_data",     32'(rx_data),     32'(mon_e.data));
        check("frame_err",   32'(frame_err),   32'(mon_e.ferr));
        check("parity_err",  32'(parity_err),  32'(mon_e.perr));
        check("overrun_err", 32'(overrun_err), 32'(mon_e.oerr));
      end
    end
  end

  task automatic expect_word(input logic done, input logic [7:0] data,
                             input logic ferr, input logic perr, input logic oerr);
    exp_t e;
    e.done = done; e.data = data; e.ferr = ferr; e.perr = perr; e.oerr = oerr;
    exp_q.push_back(e);
  endtask

  task automatic drive_bit(input logic b);
    rx_serial = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // glitch_bit >= 0 inverts one tick near the centre of that data bit
  task automatic send_frame(input logic [7:0] d, input int nb, input logic has_par,
                            input logic par_bit, input int nstop, input int glitch_bit);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) begin
      if (i == glitch_bit) begin
        rx_serial = d[i];
        repeat (BIT_CLK / 2) @(negedge clk);
        rx_serial = ~d[i];
        repeat (TICK_DIV) @(negedge clk);
        rx_serial = d[i];
        repeat (BIT_CLK / 2 - TICK_DIV) @(negedge clk);
      end else begin
        drive_bit(d[i]);
      end
    end
    if (has_par) drive_bit(par_bit);
    for (int s = 0; s < nstop; s++) drive_bit(1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  32'(rx_data),     32'h0);
    check({tag, "_done"},  32'(rx_done),     32'h0);
    check({tag, "_ferr"},  32'(frame_err),   32'h0);
    check({tag, "_perr"},  32'(parity_err),  32'h0);
    check({tag, "_oerr"},  32'(overrun_err), 32'h0);
    check({tag, "_busy"},  32'(busy),        32'h0);
  endtask

  logic [7:0] abort_byte;

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);

    // 8N1 0x55
    expect_word(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1, -1);
    drive_bit(1'b1);

    // 7 data bits, odd parity, 0x3A with wrong parity bit (correct would be 1)
    data_bits = 2'd2; par_en = 1'b1; par_odd = 1'b1;
`ifdef UART_RX_PARITY_EN
    expect_word(1'b1, 8'h3A, 1'b0, 1'b1, 1'b0);
`else
    // parity bit is taken as the stop bit when the checker is not built
    expect_word(1'b1, 8'h3A, 1'b1, 1'b0, 1'b0);
`endif
    send_frame(8'h3A, 7, 1'b1, 1'b0, 1, -1);
    drive_bit(1'b1);
    data_bits = 2'd3; par_en = 1'b0; par_odd = 1'b0;

    // Break of 20 bit-times: exactly one framing-error delivery of 0x00
    expect_word(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    rx_serial = 1'b0;
    repeat (20 * BIT_CLK) @(negedge clk);
    rx_serial = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    expect_word(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA3, 8, 1'b0, 1'b0, 1, -1);
    drive_bit(1'b1);

    // 4-tick glitch on idle line: false start, no delivery
    rx_serial = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    rx_serial = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("glitch_busy", 32'(busy), 32'h0);

    // One inverted tick in the middle of data bit 2 is outvoted
    expect_word(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1, 2);
    drive_bit(1'b1);

    // 0x55 then back-to-back 0x0F with FIFO full: overrun, data held
    expect_word(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1, -1);
    fifo_full = 1'b1;
    expect_word(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    send_frame(8'h0F, 8, 1'b0, 1'b0, 1, -1);
    fifo_full = 1'b0;
    drive_bit(1'b1);
    check("overrun_data_hold", 32'(rx_data), 32'h55);

    // Receiver disable mid-frame: immediate idle, no pulses, data held
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx_serial = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_in_frame", 32'(busy), 32'h1);
    rx_en = 1'b0;
    @(negedge clk);
    check("disable_busy", 32'(busy), 32'h0);
    rx_serial = 1'b1;
    repeat (12 * BIT_CLK) @(negedge clk);
    check("disable_data_hold", 32'(rx_data), 32'h55);
    rx_en = 1'b1;

    // Reset pulse during data bit 3
    abort_byte = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(abort_byte[i]);
    rx_serial = abort_byte[3];
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("midreset");
    rst_n = 1'b1;
    rx_serial = 1'b1;
    repeat (12 * BIT_CLK) @(negedge clk);

    // 0x96 with configuration changed mid-frame; latched settings must hold
    expect_word(1'b1, 8'h96, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'h96, 8, 1'b0, 1'b0, 1, -1);
      begin
        repeat (3 * BIT_CLK) @(negedge clk);
        data_bits = 2'd0;
        two_stop  = 1'b1;
      end
    join
    data_bits = 2'd3;
    two_stop  = 1'b0;

    repeat (4 * BIT_CLK) @(negedge clk);
    check("all_expected_delivered", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
